// File: rtl/inertial_integrator_cal_if.sv
// Sample/estimate bundle between the inertial sensor front end and the balance controller.
interface inertial_integrator_cal_if #(
  parameter int DW = 16
);
  logic                 vld;
  logic signed [DW-1:0] ptch_rt;
  logic signed [DW-1:0] AZ;
  logic                 fuse_en;
  logic                 cal_start;
  logic signed [DW-1:0] ptch;
  logic                 ptch_vld;
  logic                 cal_busy;
  logic                 cal_done;
  logic                 sat;

  modport master (
    output vld, ptch_rt, AZ, fuse_en, cal_start,
    input  ptch, ptch_vld, cal_busy, cal_done, sat
  );

  modport slave (
    input  vld, ptch_rt, AZ, fuse_en, cal_start,
    output ptch, ptch_vld, cal_busy, cal_done, sat
  );
endinterface

// File: rtl/inertial_integrator_cal.sv
// Saturating pitch integrator with accel-driven fusion nudge and run-time offset calibration.
module inertial_integrator_cal #(
  parameter int DW        = 16,
  parameter int IW        = 27,
  parameter int ACC_SCALE = 327,
  parameter int ACC_SHIFT = 13,
  parameter int FUSE_STEP = 1024,
  parameter int CAL_LOG2  = 8,
  parameter logic [DW-1:0] RT_OFF0 = 'h0050,
  parameter logic [DW-1:0] AZ_OFF0 = 'h00A0
) (
  input  logic clk,
  input  logic rst_n,
  inertial_integrator_cal_if.slave bus
);

  localparam int PW = 2 * DW;
  localparam int SW = IW + 2;
  localparam int AW = DW + CAL_LOG2;
  localparam logic signed [DW-1:0] SCALE   = DW'(ACC_SCALE);
  localparam logic signed [SW-1:0] STEP    = SW'(FUSE_STEP);
  localparam logic signed [SW-1:0] SUM_MAX = {3'b000, {(IW-1){1'b1}}};
  localparam logic signed [SW-1:0] SUM_MIN = {3'b111, {(IW-1){1'b0}}};

  typedef enum logic [1:0] {RUN, CAL_ACC, CAL_APPLY} state_t;
  state_t state, state_nx;

  logic signed [IW-1:0] ptch_int, sum_clamped;
  logic signed [PW-1:0] product;
  logic signed [DW-1:0] rt_off, az_off, rt_c, az_c, ptch_acc, ptch_cur;
  logic signed [AW-1:0] rt_acc, az_acc;
  logic [CAL_LOG2-1:0]  cnt;
  logic signed [SW-1:0] step, sum;
  logic                 clamp, run_vld, ptch_vld_q, cal_done_q, sat_q;

  assign ptch_cur = ptch_int[IW-1 -: DW];
  assign rt_c     = bus.ptch_rt - rt_off;
  assign az_c     = bus.AZ - az_off;
  // product holds the previous accepted sample, giving fusion a one-sample lag
  assign ptch_acc = DW'(product >>> ACC_SHIFT);
  assign run_vld  = (state == RUN) && bus.vld;

  always_comb begin
    step = '0;
    if (bus.fuse_en) begin
      if (ptch_acc > ptch_cur)      step = STEP;
      else if (ptch_acc < ptch_cur) step = -STEP;
    end
    sum         = SW'(ptch_int) - SW'(rt_c) + step;
    clamp       = 1'b0;
    sum_clamped = sum[IW-1:0];
    if (sum > SUM_MAX) begin
      sum_clamped = SUM_MAX[IW-1:0];
      clamp       = 1'b1;
    end else if (sum < SUM_MIN) begin
      sum_clamped = SUM_MIN[IW-1:0];
      clamp       = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      RUN:       if (bus.cal_start)            state_nx = CAL_ACC;
      CAL_ACC:   if (bus.vld && (cnt == '1))   state_nx = CAL_APPLY;
      CAL_APPLY:                               state_nx = RUN;
      default:                                 state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptch_int   <= '0;
      product    <= '0;
      rt_acc     <= '0;
      az_acc     <= '0;
      cnt        <= '0;
      rt_off     <= RT_OFF0;
      az_off     <= AZ_OFF0;
      ptch_vld_q <= 1'b0;
      cal_done_q <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      ptch_vld_q <= run_vld;
      cal_done_q <= (state == CAL_APPLY);
      case (state)
        RUN: begin
          if (bus.vld) begin
            ptch_int <= sum_clamped;
            product  <= PW'(az_c) * PW'(SCALE);
            if (clamp) sat_q <= 1'b1;
          end
          if (bus.cal_start) begin
            rt_acc <= '0;
            az_acc <= '0;
            cnt    <= '0;
          end
        end
        CAL_ACC: if (bus.vld) begin
          rt_acc <= rt_acc + AW'(bus.ptch_rt);
          az_acc <= az_acc + AW'(bus.AZ);
          cnt    <= cnt + CAL_LOG2'(1);
        end
        CAL_APPLY: begin
          rt_off   <= DW'(rt_acc >>> CAL_LOG2);
          az_off   <= DW'(az_acc >>> CAL_LOG2);
          ptch_int <= '0;
          product  <= '0;
          sat_q    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.ptch     = ptch_cur;
  assign bus.ptch_vld = ptch_vld_q;
  assign bus.cal_busy = (state != RUN);
  assign bus.cal_done = cal_done_q;
  assign bus.sat      = sat_q;

endmodule
